// File: rtl/logic_arb_pkg.sv
// Shared constants and types for the logic unit arbiter.
// Optional LOGIC_ARB_STATS_EN adds per-requester grant counters.
package logic_arb_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

endpackage

// File: rtl/bitwise_unit.sv
// Combinational SIZE-bit AND/OR/XOR/NOR unit.
// Per-bit gate primitives feed a 4:1 select on op.
module bitwise_unit
  import logic_arb_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic [1:0]      op,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic [SIZE-1:0] y
);

  logic [SIZE-1:0] y_and;
  logic [SIZE-1:0] y_or;
  logic [SIZE-1:0] y_xor;
  logic [SIZE-1:0] y_nor;

  for (genvar i = 0; i < SIZE; i++) begin : g_bit
    and u_and (y_and[i], a[i], b[i]);
    or  u_or  (y_or[i],  a[i], b[i]);
    xor u_xor (y_xor[i], a[i], b[i]);
    nor u_nor (y_nor[i], a[i], b[i]);
  end

  always_comb begin
    y = y_and;
    unique case (1'b1)
      (op == OP_AND): y = y_and;
      (op == OP_OR):  y = y_or;
      (op == OP_XOR): y = y_xor;
      (op == OP_NOR): y = y_nor;
      default:        y = y_and;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit between two requesters.
// Define LOGIC_ARB_STATS_EN to add saturating grant counters.
module logic_unit_arbiter
  import logic_arb_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  input  logic [1:0]      req0_op,
  input  logic [SIZE-1:0] req0_a,
  input  logic [SIZE-1:0] req0_b,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [1:0]      req1_op,
  input  logic [SIZE-1:0] req1_a,
  input  logic [SIZE-1:0] req1_b,
  output logic            req1_ready,
  output logic            rsp_valid,
  output logic            rsp_id,
  output logic [SIZE-1:0] rsp_data,
  output logic            rsp_zero,
  input  logic            rsp_ready
`ifdef LOGIC_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
`endif
);

  state_t          state;
  logic            last_grant;
  logic [1:0]      op_q;
  logic [SIZE-1:0] a_q;
  logic [SIZE-1:0] b_q;
  logic            id_q;
  logic [SIZE-1:0] y;
  logic            idle;
  logic            g0;
  logic            g1;

  assign idle = (state == IDLE);

  // On a tie the requester that did not win last time gets the grant
  assign g0 = req0_valid & (~req1_valid | last_grant);
  assign g1 = req1_valid & (~req0_valid | ~last_grant);

  assign req0_ready = rst_n & idle & g0;
  assign req1_ready = rst_n & idle & g1;

  bitwise_unit #(
    .SIZE (SIZE)
  ) u_unit (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_q       <= OP_AND;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req1_ready) begin
            op_q  <= req1_op;
            a_q   <= req1_a;
            b_q   <= req1_b;
            id_q  <= 1'b1;
            state <= EXEC;
          end else if (req0_ready) begin
            op_q  <= req0_op;
            a_q   <= req0_a;
            b_q   <= req0_b;
            id_q  <= 1'b0;
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= y;
          rsp_zero  <= (y == '0);
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            last_grant <= rsp_id;
            rsp_valid  <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LOGIC_ARB_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (req0_ready && cnt0_q != CNT_MAX) cnt0_q <= cnt0_q + CNT_ONE;
      if (req1_ready && cnt1_q != CNT_MAX) cnt1_q <= cnt1_q + CNT_ONE;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter.
// Stats checks are built when LOGIC_ARB_STATS_EN is defined.
module tb_logic_unit_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [1:0] req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready;
  logic       rsp_valid, rsp_id, rsp_zero, rsp_ready;
  logic [7:0] rsp_data;
`ifdef LOGIC_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic       id;
    logic [7:0] data;
    logic       zero;
  } exp_t;

  exp_t sb[$];

  logic_unit_arbiter #(.SIZE(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_zero   (rsp_zero),
    .rsp_ready  (rsp_ready)
`ifdef LOGIC_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [1:0] op,
                                       input logic [7:0] a,
                                       input logic [7:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  function automatic exp_t mk_exp(input bit id, input logic [1:0] op,
                                  input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.id   = id;
    e.data = model(op, a, b);
    e.zero = (e.data == 8'h00);
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_id",   32'(rsp_id),   32'(e.id));
        check("rsp_data", 32'(rsp_data), 32'(e.data));
        check("rsp_zero", 32'(rsp_zero), 32'(e.zero));
      end
    end
  end

  task automatic set_req(input bit id, input bit v, input logic [1:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    if (id) begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  task automatic issue(input bit id, input logic [1:0] op,
                       input logic [7:0] a, input logic [7:0] b,
                       input bit push);
    bit got = 1'b0;
    set_req(id, 1'b1, op, a, b);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = id ? req1_ready : req0_ready;
    end
    check("accept", 32'(got), 32'd1);
    if (got && push) sb.push_back(mk_exp(id, op, a, b));
    @(posedge clk); #1;
    set_req(id, 1'b0, op, a, b);
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      done = (sb.size() == 0) && !rsp_valid;
    end
    check("drain", 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit exp_id;
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    set_req(1'b0, 1'b1, 2'b00, 8'h00, 8'h00);
    set_req(1'b1, 1'b1, 2'b00, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id",    32'(rsp_id),    32'd0);
    check("rst_rsp_data",  32'(rsp_data),  32'd0);
    check("rst_rsp_zero",  32'(rsp_zero),  32'd0);
    check("rst_readys",    32'({req0_ready, req1_ready}), 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    // Single OR request and its latency
    issue(1'b0, 2'b01, 8'hA0, 8'h05, 1'b1);
    @(negedge clk);
    check("lat_exec", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("lat_resp", 32'(rsp_valid), 32'd1);
    check("or_data",  32'(rsp_data),  32'hA5);
    drain();

    // Both requesters held valid: grants alternate from 0
    do_reset();
    set_req(1'b0, 1'b1, 2'b10, 8'hFF, 8'hFF);
    set_req(1'b1, 1'b1, 2'b00, 8'h0F, 8'hF0);
    n = 0;
    exp_id = 1'b0;
    for (int c = 0; c < 100 && n < 6; c++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        check("onehot", 32'(req0_ready & req1_ready), 32'd0);
        check("grant_order", 32'(req1_ready), 32'(exp_id));
        if (req1_ready) sb.push_back(mk_exp(1'b1, 2'b00, 8'h0F, 8'hF0));
        else            sb.push_back(mk_exp(1'b0, 2'b10, 8'hFF, 8'hFF));
        exp_id = ~exp_id;
        n++;
      end
    end
    check("grant_count", 32'(n), 32'd6);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();

    // Back-pressure in RESP with stale valids present
    rsp_ready = 1'b0;
    issue(1'b0, 2'b11, 8'h00, 8'h00, 1'b1);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold",
            32'({rsp_valid, rsp_data, rsp_id, rsp_zero, req0_ready, req1_ready}),
            32'({1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0}));
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();

    // Reset during EXEC discards the operation
    issue(1'b0, 2'b10, 8'h3C, 8'h0F, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out",
          32'({rsp_valid, rsp_id, rsp_data, rsp_zero, req0_ready, req1_ready}),
          32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    set_req(1'b1, 1'b1, 2'b00, 8'hF3, 8'h3C);
    @(negedge clk);
    check("post_rst_grant", 32'(req1_ready), 32'd1);
    if (req1_ready) sb.push_back(mk_exp(1'b1, 2'b00, 8'hF3, 8'h3C));
    @(posedge clk); #1;
    req1_valid = 1'b0;
    drain();

`ifdef LOGIC_ARB_STATS_EN
    do_reset();
    for (int i = 0; i < 5; i++) issue(1'b0, 2'b01, 8'(i), 8'h10, 1'b1);
    for (int i = 0; i < 3; i++) issue(1'b1, 2'b10, 8'(i), 8'h55, 1'b1);
    drain();
    check("cnt0", 32'(grant_cnt0), 32'd5);
    check("cnt1", 32'(grant_cnt1), 32'd3);
    force dut.cnt0_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.cnt0_q;
    issue(1'b0, 2'b00, 8'hC3, 8'h81, 1'b1);
    drain();
    check("cnt0_sat", 32'(grant_cnt0), 32'hFFFF);
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
